// File: rtl/des_pkg.sv
// Shared definitions for the DES block packer: block geometry, packer states, pad helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package des_pkg;

   localparam int BLK_W    = 64;   // DES block width in bits
   localparam int PKCS_BLK = 8;    // PKCS#5 block size in bytes

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,   // collecting plaintext bytes
      ST_PAD     = 2'd1,   // final partial block waiting to be padded and emitted
      ST_FULLPAD = 2'd2    // message ended on a block boundary, extra pad block owed
   } pk_state_t;

   localparam logic [BLK_W-1:0] FULL_PAD_BLK = {PKCS_BLK{8'h08}};

   // Pad byte for a final block holding n (1..7) message bytes.
   function automatic logic [7:0] pad_value(input logic [2:0] n, input bit pkcs);
      pad_value = pkcs ? (8'd8 - {5'd0, n}) : 8'h00;
   endfunction

endpackage

// File: rtl/des_pad_fill.sv
// Merges the first nbytes bytes of an assembled block with a pad byte in all later positions.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: blk = assembled bytes, byte 0 in [63:56]; nbytes = valid byte count (1..7);
//        pad = fill byte; blk_out = merged block.
module des_pad_fill
   import des_pkg::*;
(
   input  logic [BLK_W-1:0] blk,
   input  logic [2:0]       nbytes,
   input  logic [7:0]       pad,
   output logic [BLK_W-1:0] blk_out
);

   always_comb begin
      blk_out = blk;
      for (int k = 0; k < PKCS_BLK; k++) begin
         if (!(k[2:0] < nbytes)) begin
            blk_out[BLK_W-1-8*k -: 8] = pad;
         end
      end
   end

endmodule

// File: rtl/des_block_packer.sv
// Packs a plaintext byte stream into 64-bit DES blocks, padding the final block (PKCS#5 or zero).
// Latency: a completing byte or pad step shows on msg_valid the next cycle.
// Backpressure: valid/ready on both sides; in_ready drops while padding or when a full block cannot be handed off.
// Ports: clk/rst (sync, active high); in_byte/in_valid/in_last/in_ready = byte input;
//        message[64:1]/msg_valid/msg_last/msg_ready = block output, first byte in message[64:57].
module des_block_packer
   import des_pkg::*;
#(
   parameter bit PAD_EN = 1'b1
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_byte,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [64:1]   message,
   output logic          msg_valid,
   input  logic          msg_ready,
   output logic          msg_last
);

   pk_state_t        state_q, state_d;
   logic [BLK_W-1:0] asm_q, asm_d;
   logic [BLK_W-1:0] msg_q;
   logic [BLK_W-1:0] ld_dat;
   logic [BLK_W-1:0] pad_blk;
   logic [2:0]       cnt_q, cnt_d;
   logic [7:0]       pad_byte;
   logic             msg_valid_q, msg_last_q;
   logic             out_free, acc, ld, ld_last;

   // The output register can take a new block if it is empty or being drained this cycle.
   assign out_free = !msg_valid_q || msg_ready;

   // The 8th byte completes a block immediately, so it may only enter when the block can leave.
   assign in_ready = !rst && (state_q == ST_FILL) && !((cnt_q == 3'd7) && !out_free);
   assign acc      = in_valid && in_ready;

   // In PAD the counter holds the number of message bytes in the final block.
   assign pad_byte = pad_value(cnt_q, PAD_EN);

   des_pad_fill u_pad_fill (
      .blk     (asm_q),
      .nbytes  (cnt_q),
      .pad     (pad_byte),
      .blk_out (pad_blk)
   );

   // Drop the accepted byte into its slot; the 8th byte is visible in asm_d the same cycle.
   always_comb begin
      asm_d = asm_q;
      for (int k = 0; k < PKCS_BLK; k++) begin
         if (acc && (cnt_q == k[2:0])) begin
            asm_d[BLK_W-1-8*k -: 8] = in_byte;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ld      = 1'b0;
      ld_dat  = '0;
      ld_last = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (acc) begin
               if (cnt_q == 3'd7) begin
                  ld     = 1'b1;
                  ld_dat = asm_d;
                  cnt_d  = 3'd0;
                  if (in_last) begin
                     if (PAD_EN) begin
                        state_d = ST_FULLPAD;
                     end else begin
                        ld_last = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
                  if (in_last) begin
                     state_d = ST_PAD;
                  end
               end
            end
         end
         ST_PAD: begin
            if (out_free) begin
               ld      = 1'b1;
               ld_dat  = pad_blk;
               ld_last = 1'b1;
               cnt_d   = 3'd0;
               state_d = ST_FILL;
            end
         end
         ST_FULLPAD: begin
            if (out_free) begin
               ld      = 1'b1;
               ld_dat  = FULL_PAD_BLK;
               ld_last = 1'b1;
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FILL;
         cnt_q       <= 3'd0;
         asm_q       <= '0;
         msg_q       <= '0;
         msg_valid_q <= 1'b0;
         msg_last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         if (ld) begin
            msg_q       <= ld_dat;
            msg_last_q  <= ld_last;
            msg_valid_q <= 1'b1;
         end else if (msg_ready) begin
            msg_valid_q <= 1'b0;
         end
      end
   end

   assign message   = msg_q;
   assign msg_valid = msg_valid_q;
   assign msg_last  = msg_last_q;

endmodule

// File: tb/tb_des_block_packer.sv
// Self-checking bench for des_block_packer: one PKCS#5 instance and one zero-fill instance.
// Latency: n/a (testbench).
// Backpressure: msg_ready driven always-high, random or held low per instance.
module tb_des_block_packer;

   logic        clk;
   logic        rst;
   logic [7:0]  in_byte   [2];
   logic        in_valid  [2];
   logic        in_last   [2];
   logic        in_ready  [2];
   logic [64:1] message   [2];
   logic        msg_valid [2];
   logic        msg_ready [2];
   logic        msg_last  [2];

   logic [64:0] got_q [2][$];
   logic [64:0] exp_q [2][$];
   logic [64:0] held  [2];
   logic        hold_v[2];
   int          rdy_mode[2];   // 0 = always ready, 1 = random, 2 = held low
   int          tests;
   int          fails;

   des_block_packer #(.PAD_EN(1'b1)) u_pkcs (
      .clk(clk), .rst(rst),
      .in_byte(in_byte[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
      .message(message[0]), .msg_valid(msg_valid[0]), .msg_ready(msg_ready[0]), .msg_last(msg_last[0])
   );

   des_block_packer #(.PAD_EN(1'b0)) u_zero (
      .clk(clk), .rst(rst),
      .in_byte(in_byte[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
      .message(message[1]), .msg_valid(msg_valid[1]), .msg_ready(msg_ready[1]), .msg_last(msg_last[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Downstream ready driver.
   initial begin
      msg_ready[0] = 1'b1;
      msg_ready[1] = 1'b1;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            case (rdy_mode[i])
               1:       msg_ready[i] = 1'($urandom_range(0, 1));
               2:       msg_ready[i] = 1'b0;
               default: msg_ready[i] = 1'b1;
            endcase
         end
      end
   end

   // Collect handed-off blocks and check that a stalled block holds still.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            hold_v[i] <= 1'b0;
         end else begin
            if (hold_v[i]) chk("hold_stable", {msg_last[i], message[i]}, held[i]);
            if (msg_valid[i] && msg_ready[i]) got_q[i].push_back({msg_last[i], message[i]});
            hold_v[i] <= msg_valid[i] && !msg_ready[i];
            held[i]   <= {msg_last[i], message[i]};
         end
      end
   end

   // Reference: split the message into 8-byte blocks, then apply the padding rule.
   function automatic void model(input int idx, input bit pad_en, input logic [7:0] b[$]);
      int          n, full, rem;
      logic [63:0] blk;
      bit          lst;
      n    = b.size();
      full = n / 8;
      rem  = n % 8;
      for (int i = 0; i < full; i++) begin
         blk = '0;
         for (int j = 0; j < 8; j++) blk = {blk[55:0], b[8*i+j]};
         lst = (i == full - 1) && (rem == 0) && !pad_en;
         exp_q[idx].push_back({lst, blk});
      end
      if (rem > 0) begin
         blk = '0;
         for (int j = 0; j < 8; j++)
            blk = {blk[55:0], (j < rem) ? b[8*full+j] : (pad_en ? 8'(8 - rem) : 8'h00)};
         exp_q[idx].push_back({1'b1, blk});
      end else if (pad_en) begin
         exp_q[idx].push_back({1'b1, 64'h0808080808080808});
      end
   endfunction

   task automatic send(input int idx, input logic [7:0] b[$], input bit mark_last, input bit gaps);
      int tmo;
      for (int i = 0; i < b.size(); i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            in_valid[idx] = 1'b0;
            in_last[idx]  = 1'b0;
         end
         @(negedge clk);
         in_valid[idx] = 1'b1;
         in_byte[idx]  = b[i];
         in_last[idx]  = mark_last && (i == b.size() - 1);
         #1;
         tmo = 0;
         while (!in_ready[idx] && tmo < 300) begin
            @(negedge clk);
            #1;
            tmo++;
         end
         if (!in_ready[idx]) begin
            chk("send_ready_timeout", 65'(in_ready[idx]), 65'd1);
            break;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid[idx] = 1'b0;
      in_last[idx]  = 1'b0;
   endtask

   task automatic wait_blocks(input int idx, input string tag);
      int t;
      t = 0;
      while (got_q[idx].size() < exp_q[idx].size() && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, 65'(got_q[idx].size()), 65'(exp_q[idx].size()));
      while (got_q[idx].size() > 0 && exp_q[idx].size() > 0)
         chk(tag, got_q[idx].pop_front(), exp_q[idx].pop_front());
      got_q[idx].delete();
      exp_q[idx].delete();
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst0", 65'(in_ready[0]), 65'd1);
      chk("ready_after_rst1", 65'(in_ready[1]), 65'd1);
   endtask

   initial begin
      logic [7:0] b[$];
      int         t;
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_byte[i]  = 8'h00;
         in_valid[i] = 1'b0;
         in_last[i]  = 1'b0;
         rdy_mode[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_in_ready",  65'(in_ready[i]),  65'd0);
         chk("rst_msg_valid", 65'(msg_valid[i]), 65'd0);
         chk("rst_msg_last",  65'(msg_last[i]),  65'd0);
         chk("rst_message",   65'(message[i]),   65'd0);
      end
      rst = 1'b0;
      #1;
      chk("ready_first_cycle", 65'(in_ready[0]), 65'd1);

      // Exactly one block, PKCS#5: full pad block follows
      b = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      model(0, 1'b1, b);
      send(0, b, 1'b1, 1'b0);
      wait_blocks(0, "full_block_pkcs");

      // Same message, zero-fill: single final block
      model(1, 1'b0, b);
      send(1, b, 1'b1, 1'b0);
      wait_blocks(1, "full_block_zero");

      // Short message, both padding modes
      b = {8'hAA, 8'hBB, 8'hCC};
      model(0, 1'b1, b);
      send(0, b, 1'b1, 1'b0);
      wait_blocks(0, "short_pkcs");
      model(1, 1'b0, b);
      send(1, b, 1'b1, 1'b0);
      wait_blocks(1, "short_zero");

      // 16 bytes with the first block stalled for several cycles
      b = {};
      for (int k = 0; k < 16; k++) b.push_back(8'(k));
      model(0, 1'b1, b);
      rdy_mode[0] = 2;
      fork
         send(0, b, 1'b1, 1'b0);
         begin
            t = 0;
            while (!msg_valid[0] && t < 100) begin
               @(negedge clk);
               t++;
            end
            repeat (5) @(negedge clk);
            #1;
            chk("stall_message", {msg_last[0], message[0]}, {1'b0, 64'h0001020304050607});
            rdy_mode[0] = 0;
         end
      join
      wait_blocks(0, "stream16");

      // in_ready must drop on the 8th byte of a block when the previous block is stuck
      b = {};
      for (int k = 0; k < 16; k++) b.push_back(8'(8'h10 + k));
      model(1, 1'b0, b);
      rdy_mode[1] = 2;
      send(1, b[0:14], 1'b0, 1'b0);
      #1;
      chk("ready_drop", 65'(in_ready[1]), 65'd0);
      chk("ready_drop_valid", 65'(msg_valid[1]), 65'd1);
      rdy_mode[1] = 0;
      send(1, b[15:15], 1'b1, 1'b0);
      wait_blocks(1, "ready_drop_blocks");

      // Reset with a pending output block and a partial block: nothing emitted
      b = {};
      for (int k = 0; k < 10; k++) b.push_back(8'(8'hA0 + k));
      rdy_mode[0] = 2;
      send(0, b, 1'b0, 1'b0);
      b = {8'h01, 8'h02, 8'h03, 8'h04};
      send(1, b, 1'b0, 1'b0);
      pulse_rst();
      rdy_mode[0] = 0;
      repeat (6) @(negedge clk);
      chk("rst_discard_count0", 65'(got_q[0].size()), 65'd0);
      chk("rst_discard_valid0", 65'(msg_valid[0]), 65'd0);
      b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      model(1, 1'b0, b);
      send(1, b, 1'b1, 1'b0);
      wait_blocks(1, "after_rst");

      // Random messages, random input gaps and downstream stalls
      rdy_mode[0] = 1;
      rdy_mode[1] = 1;
      for (int m = 0; m < 25; m++) begin
         for (int i = 0; i < 2; i++) begin
            b = {};
            for (int k = 0; k < int'($urandom_range(1, 20)); k++) b.push_back(8'($urandom));
            model(i, (i == 0), b);
            send(i, b, 1'b1, 1'b1);
            wait_blocks(i, "random");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/des_block_packer.md
DES_BLOCK_PACKER -- requirements
Module: des_block_packer

Interface
REQ-001 SHALL have parameter: PAD_EN, default 1, 1 = PKCS#5 padding, 0 = zero-fill final partial block.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_byte  input  8  plaintext byte.
REQ-005 SHALL have port: in_valid  input  1  in_byte/in_last valid.
REQ-006 SHALL have port: in_last  input  1  final byte of message.
REQ-007 SHALL have port: in_ready  output  1  packer accepts byte this cycle.
REQ-008 SHALL have port: message  output  [64:1]  assembled block for the DES encrypt stage.
REQ-009 SHALL have port: msg_valid  output  1  message valid.
REQ-010 SHALL have port: msg_ready  input  1  downstream consumes message.
REQ-011 SHALL have port: msg_last  output  1  block is final block of message.

Function
REQ-012 SHALL transfer a byte when in_valid && in_ready, and a block when msg_valid && msg_ready.
REQ-013 SHALL place the k-th accepted byte of a block (k=1..8) at message[72-8k : 65-8k]; first byte in [64:57], eighth in [8:1].
REQ-014 SHALL keep a separate 64-bit assembly register, a 3-bit byte counter and a 64-bit output register; output register is free when !msg_valid || msg_ready.
REQ-015 SHALL implement states FILL, PAD, FULLPAD; in_ready low outside FILL.
REQ-016 In FILL, in_ready SHALL be 1 except when counter==7 and output register not free.
REQ-017 On 8th byte accepted without in_last: output register loads block next cycle, msg_valid=1, msg_last=0, counter wraps to 0, stay FILL.
REQ-018 On in_last accepted with n bytes in block, n<8: go to PAD; in PAD, when output free, load assembled bytes plus (8-n) pad bytes, msg_last=1, counter=0, go to FILL.
REQ-019 Pad byte value SHALL be 8-n when PAD_EN=1, 0x00 when PAD_EN=0.
REQ-020 On in_last accepted with n==8: load block with msg_last=0 and go to FULLPAD when PAD_EN=1; load block with msg_last=1 and stay in FILL when PAD_EN=0.
REQ-021 In FULLPAD, when output free, SHALL load 64'h0808080808080808, msg_last=1, go to FILL.
REQ-022 While msg_valid=1 && msg_ready=0, message and msg_last SHALL hold stable.
REQ-023 Back-to-back blocks SHALL be supported: output register reloads in the same cycle it is drained.
REQ-024 Latency: a completing byte or pad step SHALL appear on msg_valid the next cycle.

Reset
REQ-025 rst=1 SHALL force state FILL, counter 0, assembly register 0, message 0, msg_valid 0, msg_last 0, in_ready 0 during reset.
REQ-026 rst asserted mid-block or mid-pad SHALL discard the partial block and any pending output block without emitting it.
REQ-027 in_ready SHALL go 1 the first cycle after rst deasserts.

Structure
REQ-028 State encodings, block width (64) and PKCS block size (8) SHALL live in shared package file des_pkg.vh.
REQ-029 SHALL instantiate one sub-module des_pad_fill: combinational, merges n valid bytes with pad value into a 64-bit block.
REQ-030 message SHALL connect directly to the message input of the existing encrypt stage, same [64:1] bit numbering.

Verification
REQ-031 Bytes 01 23 45 67 89 AB CD EF, last on EF, msg_ready=1 -> 0123456789ABCDEF msg_last=0, then 0808080808080808 msg_last=1.
REQ-032 Bytes AA BB CC, last on CC -> AABBCC0505050505 msg_last=1; with PAD_EN=0 -> AABBCC0000000000 msg_last=1.
REQ-033 16 bytes 00..0F streamed, msg_ready low 5 cycles on first block -> message holds 0001020304050607; in_ready drops at 8th-byte slot; second block 08090A0B0C0D0E0F follows with no loss.
REQ-034 rst pulsed after 4 bytes, then 8 fresh bytes 11..88 -> only block 1122334455667788 emitted.
REQ-035 Packer feeding encrypt stage, key 133457799BBCDFF1, bytes 01..EF as in REQ-031 -> first ciphertext 85E813540F0AB405.
